// File: rtl/sensor_vote_monitor.sv
// ============================================================================
// Module  : sensor_vote_monitor
// Brief   : Per-sensor debounce, low-sensor vote and confirmed, latched alarm.
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sensor_vote_monitor #(
  parameter int N_SENSORS = 7,
  parameter int THRESHOLD = 2,
  parameter int DEBOUNCE  = 3,
  parameter int CONFIRM   = 4,
  localparam int CW       = $clog2(N_SENSORS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N_SENSORS-1:0] sensor_in,
  input  logic                 ack,
  output logic [N_SENSORS-1:0] low_mask,
  output logic [CW-1:0]        low_count,
  output logic                 trip,
  output logic                 armed,
  output logic                 alarm,
  output logic [7:0]           trip_events
);

  localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int CFW = $clog2(CONFIRM + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  // Each bit only flips after DEBOUNCE consecutive differing samples.
  for (genvar i = 0; i < N_SENSORS; i++) begin : g_db
    logic           state_q, state_d;
    logic [DCW-1:0] cnt_q, cnt_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (sensor_in[i] != state_q) begin
        if (cnt_q == DCW'(DEBOUNCE - 1)) begin
          state_d = sensor_in[i];
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign low_mask[i] = ~state_q;
  end

  always_comb begin
    low_count = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      low_count = low_count + CW'(low_mask[k]);
    end
  end

  assign trip = (low_count >= CW'(THRESHOLD));

  logic [1:0]     state_q, state_d;
  logic [CFW-1:0] conf_q, conf_d;
  logic [7:0]     events_q, events_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      conf_q   <= '0;
      events_q <= '0;
    end else begin
      state_q  <= state_d;
      conf_q   <= conf_d;
      events_q <= events_d;
    end
  end

  // Disabling wins over ALARM entry, so no event is counted on that edge.
  always_comb begin
    state_d  = state_q;
    conf_d   = conf_q;
    events_d = events_q;
    if (!en) begin
      state_d = ST_IDLE;
      conf_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          conf_d = '0;
          if (trip) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (!trip) begin
            state_d = ST_IDLE;
            conf_d  = '0;
          end else if (conf_q == CFW'(CONFIRM - 1)) begin
            state_d = ST_ALARM;
            conf_d  = '0;
            if (events_q != 8'hFF) events_d = events_q + 8'd1;
          end else begin
            conf_d = conf_q + CFW'(1);
          end
        end
        ST_ALARM: begin
          if (ack && !trip) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          conf_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    armed = (state_q == ST_ARM);
    alarm = (state_q == ST_ALARM);
  end

  assign trip_events = events_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_vote_monitor.sv
// ============================================================================
// Module  : tb_sensor_vote_monitor
// Brief   : Directed checks of sensor_vote_monitor with default parameters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_vote_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [6:0] sensor_in;
  logic       ack;
  logic [6:0] low_mask;
  logic [2:0] low_count;
  logic       trip;
  logic       armed;
  logic       alarm;
  logic [7:0] trip_events;

  int checks = 0;
  int errors = 0;

  sensor_vote_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sensor_in   (sensor_in),
    .ack         (ack),
    .low_mask    (low_mask),
    .low_count   (low_count),
    .trip        (trip),
    .armed       (armed),
    .alarm       (alarm),
    .trip_events (trip_events)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sensor_in = 7'h7F; ack = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_mask",   low_mask,    32'h0);
    chk("rst_count",  low_count,   32'h0);
    chk("rst_trip",   trip,        32'h0);
    chk("rst_armed",  armed,       32'h0);
    chk("rst_alarm",  alarm,       32'h0);
    chk("rst_events", trip_events, 32'h0);

    // Two sensors low: mask after 3 edges, ARM after 4, ALARM after 8
    sensor_in = 7'b1111100; en = 1'b1;
    tick(2);
    chk("t1_mask_e2", low_mask, 32'h00);
    tick(1);
    chk("t1_mask_e3",  low_mask,  32'h03);
    chk("t1_count_e3", low_count, 32'd2);
    chk("t1_trip_e3",  trip,      32'h1);
    chk("t1_armed_e3", armed,     32'h0);
    tick(1);
    chk("t1_armed_e4", armed, 32'h1);
    tick(3);
    chk("t1_alarm_e7", alarm, 32'h0);
    chk("t1_armed_e7", armed, 32'h1);
    tick(1);
    chk("t1_alarm_e8",  alarm,       32'h1);
    chk("t1_armed_e8",  armed,       32'h0);
    chk("t1_events_e8", trip_events, 32'd1);

    // Ack while still tripped is ignored; release, then ack clears
    ack = 1'b1;
    tick(1);
    chk("t3_ack_trip", alarm, 32'h1);
    ack = 1'b0; sensor_in = 7'h7F;
    tick(2);
    chk("t3_mask_hold", low_mask, 32'h03);
    tick(1);
    chk("t3_mask_clr",  low_mask, 32'h00);
    chk("t3_trip_clr",  trip,     32'h0);
    chk("t3_latched",   alarm,    32'h1);
    ack = 1'b1;
    tick(1);
    chk("t3_alarm_clr", alarm, 32'h0);
    ack = 1'b0;
    chk("t3_events", trip_events, 32'd1);

    // Ack held while trip falls: exit one edge after the mask clears
    sensor_in = 7'b1111100;
    tick(8);
    chk("t3b_alarm",  alarm,       32'h1);
    chk("t3b_events", trip_events, 32'd2);
    sensor_in = 7'h7F; ack = 1'b1;
    tick(3);
    chk("t3b_mask_clr", low_mask, 32'h00);
    chk("t3b_alarm_e3", alarm,    32'h1);
    tick(1);
    chk("t3b_alarm_e4", alarm, 32'h0);
    ack = 1'b0;

    // Glitch of two samples is rejected
    sensor_in = 7'b1111110;
    tick(2);
    sensor_in = 7'h7F;
    tick(1);
    chk("t2_mask", low_mask, 32'h00);
    tick(3);
    chk("t2_mask_late", low_mask, 32'h00);
    chk("t2_armed",     armed,    32'h0);

    // Trip falls during ARM: back to IDLE, no event
    sensor_in = 7'b1111100;
    tick(4);
    chk("t4_armed", armed, 32'h1);
    sensor_in = 7'b1111110;
    tick(2);
    chk("t4_armed_mid", armed,     32'h1);
    chk("t4_count_mid", low_count, 32'd2);
    tick(1);
    chk("t4_mask_one", low_mask, 32'h01);
    chk("t4_trip_off", trip,     32'h0);
    tick(1);
    chk("t4_idle",   armed,       32'h0);
    chk("t4_alarm",  alarm,       32'h0);
    chk("t4_events", trip_events, 32'd2);
    sensor_in = 7'h7F;
    tick(3);
    chk("t4_mask_clr", low_mask, 32'h00);

    // All low; en drop mid-ARM; reset mid-ALARM
    sensor_in = 7'h00;
    tick(3);
    chk("t5_count7", low_count, 32'd7);
    chk("t5_mask",   low_mask,  32'h7F);
    tick(1);
    chk("t5_armed", armed, 32'h1);
    en = 1'b0;
    tick(1);
    chk("t5_en_idle", armed, 32'h0);
    en = 1'b1;
    tick(1);
    chk("t5_rearm", armed, 32'h1);
    tick(4);
    chk("t5_alarm",  alarm,       32'h1);
    chk("t5_events", trip_events, 32'd3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_rst_mask",   low_mask,    32'h0);
    chk("t5_rst_count",  low_count,   32'h0);
    chk("t5_rst_armed",  armed,       32'h0);
    chk("t5_rst_alarm",  alarm,       32'h0);
    chk("t5_rst_events", trip_events, 32'h0);

    // en falling on the ALARM-entry edge
    tick(3);
    tick(1);
    chk("t5b_armed", armed, 32'h1);
    tick(3);
    chk("t5b_armed_late", armed, 32'h1);
    en = 1'b0;
    tick(1);
    chk("t5b_idle",   armed,       32'h0);
    chk("t5b_alarm",  alarm,       32'h0);
    chk("t5b_events", trip_events, 32'h0);
    en = 1'b1;
    sensor_in = 7'h7F;
    tick(3);
    chk("t5b_mask_clr", low_mask, 32'h00);

    // 300 alarm/ack rounds: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      sensor_in = 7'h00;
      tick(8);
      chk("t6_alarm",  alarm,       32'h1);
      chk("t6_events", trip_events, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      sensor_in = 7'h7F; ack = 1'b1;
      tick(4);
      ack = 1'b0;
      chk("t6_cleared", alarm, 32'h0);
    end
    chk("t6_final", trip_events, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
